// File: rtl/udma_i2c_cfg_pkg.sv
// Shared types and register map for the uDMA I2C config-bus initiator.
// Holds the FSM state set, the channel register addresses and the CFG/STATUS bit layout.
package udma_i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_RX_SADDR,
    ST_WR_RX_SIZE,
    ST_WR_RX_CFG,
    ST_WR_TX_SADDR,
    ST_WR_TX_SIZE,
    ST_WR_TX_CFG,
    ST_POLL_WAIT,
    ST_POLL_RD,
    ST_DONE
  } state_e;

  localparam logic [4:0] REG_RX_SADDR = 5'h00;
  localparam logic [4:0] REG_RX_SIZE  = 5'h01;
  localparam logic [4:0] REG_RX_CFG   = 5'h02;
  localparam logic [4:0] REG_TX_SADDR = 5'h04;
  localparam logic [4:0] REG_TX_SIZE  = 5'h05;
  localparam logic [4:0] REG_TX_CFG   = 5'h06;
  localparam logic [4:0] REG_STATUS   = 5'h08;
  localparam logic [4:0] REG_SETUP    = 5'h09;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_AL      = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  localparam int CFG_CONT_BIT  = 0;
  localparam int CFG_EN_BIT    = 4;
  localparam int CFG_CLR_BIT   = 5;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_AL_BIT   = 1;

  // Register-write sequence; disabled channels are skipped, and the sequence always ends in polling.
  function automatic state_e next_step(state_e s, logic rx_en, logic tx_en);
    case (s)
      ST_IDLE:        return rx_en ? ST_WR_RX_SADDR : (tx_en ? ST_WR_TX_SADDR : ST_POLL_WAIT);
      ST_WR_RX_SADDR: return ST_WR_RX_SIZE;
      ST_WR_RX_SIZE:  return ST_WR_RX_CFG;
      ST_WR_RX_CFG:   return tx_en ? ST_WR_TX_SADDR : ST_POLL_WAIT;
      ST_WR_TX_SADDR: return ST_WR_TX_SIZE;
      ST_WR_TX_SIZE:  return ST_WR_TX_CFG;
      default:        return ST_POLL_WAIT;
    endcase
  endfunction

  function automatic logic [4:0] reg_addr(state_e s);
    case (s)
      ST_WR_RX_SADDR: return REG_RX_SADDR;
      ST_WR_RX_SIZE:  return REG_RX_SIZE;
      ST_WR_RX_CFG:   return REG_RX_CFG;
      ST_WR_TX_SADDR: return REG_TX_SADDR;
      ST_WR_TX_SIZE:  return REG_TX_SIZE;
      ST_WR_TX_CFG:   return REG_TX_CFG;
      ST_POLL_RD:     return REG_STATUS;
      default:        return 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] cfg_word(logic cont);
    logic [31:0] w;
    w = '0;
    w[CFG_CLR_BIT]  = 1'b0;
    w[CFG_EN_BIT]   = 1'b1;
    w[CFG_CONT_BIT] = cont;
    return w;
  endfunction

endpackage

// File: rtl/udma_i2c_cfg_master.sv
// Config-bus initiator: arms the RX/TX uDMA channels of the I2C core with register writes,
// then polls STATUS until idle, arbitration lost, or poll timeout.
module udma_i2c_cfg_master
  import udma_i2c_cfg_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_GAP       = 16,
  parameter int MAX_POLLS      = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rx_en_i,
  input  logic                      req_tx_en_i,
  input  logic                      req_continuous_i,
  input  logic [L2_AWIDTH_NOAL-1:0] req_rx_saddr_i,
  input  logic [TRANS_SIZE-1:0]     req_rx_size_i,
  input  logic [L2_AWIDTH_NOAL-1:0] req_tx_saddr_i,
  input  logic [TRANS_SIZE-1:0]     req_tx_size_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                done_status_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  output logic [4:0]                cfg_addr_o,
  output logic [31:0]               cfg_data_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i
);

  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int POLL_W = $clog2(MAX_POLLS + 1);

  state_e                    state_reg;
  logic                      rx_en_reg, tx_en_reg, cont_reg;
  logic [L2_AWIDTH_NOAL-1:0] rx_saddr_reg, tx_saddr_reg;
  logic [TRANS_SIZE-1:0]     rx_size_reg, tx_size_reg;
  logic [GAP_W-1:0]          gap_cnt_reg;
  logic [POLL_W-1:0]         poll_cnt_reg;

  logic   accept, wr_state, step_go;
  state_e step_next;
  logic   [31:0] step_data_next;
  logic   sel_rx_en, sel_tx_en, sel_cont;
  logic   [L2_AWIDTH_NOAL-1:0] sel_rx_saddr, sel_tx_saddr;
  logic   [TRANS_SIZE-1:0]     sel_rx_size, sel_tx_size;
  logic   unused_status_bits;

  assign unused_status_bits = ^cfg_data_i[31:2];

  // On accept the latches load on the same edge as the first bus access, so use the live request.
  always_comb begin
    accept       = (state_reg == ST_IDLE) && req_valid_i;
    wr_state     = state_reg inside {ST_WR_RX_SADDR, ST_WR_RX_SIZE, ST_WR_RX_CFG,
                                     ST_WR_TX_SADDR, ST_WR_TX_SIZE, ST_WR_TX_CFG};
    step_go      = accept || (wr_state && cfg_ready_i);
    sel_rx_en    = accept ? req_rx_en_i      : rx_en_reg;
    sel_tx_en    = accept ? req_tx_en_i      : tx_en_reg;
    sel_cont     = accept ? req_continuous_i : cont_reg;
    sel_rx_saddr = accept ? req_rx_saddr_i   : rx_saddr_reg;
    sel_rx_size  = accept ? req_rx_size_i    : rx_size_reg;
    sel_tx_saddr = accept ? req_tx_saddr_i   : tx_saddr_reg;
    sel_tx_size  = accept ? req_tx_size_i    : tx_size_reg;
    step_next    = next_step(state_reg, sel_rx_en, sel_tx_en);
    step_data_next = '0;
    case (step_next)
      ST_WR_RX_SADDR: step_data_next[L2_AWIDTH_NOAL-1:0] = sel_rx_saddr;
      ST_WR_RX_SIZE:  step_data_next[TRANS_SIZE-1:0]     = sel_rx_size;
      ST_WR_TX_SADDR: step_data_next[L2_AWIDTH_NOAL-1:0] = sel_tx_saddr;
      ST_WR_TX_SIZE:  step_data_next[TRANS_SIZE-1:0]     = sel_tx_size;
      ST_WR_RX_CFG,
      ST_WR_TX_CFG:   step_data_next = cfg_word(sel_cont);
      default:        step_data_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      req_ready_o   <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      done_status_o <= STATUS_OK;
      cfg_valid_o   <= 1'b0;
      cfg_rwn_o     <= 1'b0;
      cfg_addr_o    <= '0;
      cfg_data_o    <= '0;
      rx_en_reg     <= 1'b0;
      tx_en_reg     <= 1'b0;
      cont_reg      <= 1'b0;
      rx_saddr_reg  <= '0;
      rx_size_reg   <= '0;
      tx_saddr_reg  <= '0;
      tx_size_reg   <= '0;
      gap_cnt_reg   <= '0;
      poll_cnt_reg  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            rx_en_reg    <= req_rx_en_i;
            tx_en_reg    <= req_tx_en_i;
            cont_reg     <= req_continuous_i;
            rx_saddr_reg <= req_rx_saddr_i;
            rx_size_reg  <= req_rx_size_i;
            tx_saddr_reg <= req_tx_saddr_i;
            tx_size_reg  <= req_tx_size_i;
            req_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            gap_cnt_reg  <= '0;
            poll_cnt_reg <= '0;
          end
        end
        ST_POLL_WAIT: begin
          if (gap_cnt_reg == GAP_W'(POLL_GAP - 1)) begin
            gap_cnt_reg <= '0;
            state_reg   <= ST_POLL_RD;
            cfg_valid_o <= 1'b1;
            cfg_rwn_o   <= 1'b1;
            cfg_addr_o  <= REG_STATUS;
            cfg_data_o  <= '0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        ST_POLL_RD: begin
          if (cfg_ready_i) begin
            cfg_valid_o <= 1'b0;
            cfg_rwn_o   <= 1'b0;
            // Arbitration loss takes priority over a still-busy core.
            if (cfg_data_i[STAT_AL_BIT]) begin
              state_reg     <= ST_DONE;
              done_o        <= 1'b1;
              done_status_o <= STATUS_AL;
            end else if (!cfg_data_i[STAT_BUSY_BIT]) begin
              state_reg     <= ST_DONE;
              done_o        <= 1'b1;
              done_status_o <= STATUS_OK;
            end else if (poll_cnt_reg == POLL_W'(MAX_POLLS - 1)) begin
              state_reg     <= ST_DONE;
              done_o        <= 1'b1;
              done_status_o <= STATUS_TIMEOUT;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + 1'b1;
              state_reg    <= ST_POLL_WAIT;
            end
          end
        end
        ST_DONE: begin
          state_reg   <= ST_IDLE;
          busy_o      <= 1'b0;
          req_ready_o <= 1'b1;
        end
        default: ;
      endcase
      if (step_go) begin
        state_reg   <= step_next;
        cfg_valid_o <= (step_next != ST_POLL_WAIT);
        cfg_rwn_o   <= 1'b0;
        cfg_addr_o  <= reg_addr(step_next);
        cfg_data_o  <= step_data_next;
      end
    end
  end

endmodule

// File: tb/tb_udma_i2c_cfg_master.sv
// Directed bench for udma_i2c_cfg_master with a bus log, stall injector and STATUS feed.
`define CHK(TAG, OBS, EXP) begin n_tests++; assert ((OBS) === (EXP)) else begin n_fail++; $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); end end

module tb_udma_i2c_cfg_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_rx_en_i = 1'b0, req_tx_en_i = 1'b0, req_continuous_i = 1'b0;
  logic [11:0] req_rx_saddr_i = '0, req_tx_saddr_i = '0;
  logic [15:0] req_rx_size_i = '0, req_tx_size_i = '0;
  logic        busy_o, done_o;
  logic [1:0]  done_status_o;
  logic        cfg_valid_o, cfg_rwn_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;

  int n_tests = 0;
  int n_fail  = 0;

  udma_i2c_cfg_master #(
    .L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_GAP(16), .MAX_POLLS(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rx_en_i(req_rx_en_i), .req_tx_en_i(req_tx_en_i),
    .req_continuous_i(req_continuous_i),
    .req_rx_saddr_i(req_rx_saddr_i), .req_rx_size_i(req_rx_size_i),
    .req_tx_saddr_i(req_tx_saddr_i), .req_tx_size_i(req_tx_size_i),
    .busy_o(busy_o), .done_o(done_o), .done_status_o(done_status_o),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Bus log, written only by the monitor
  int          cyc = 0, log_n = 0, rd_total = 0, stall_total = 0, stable_err = 0, idle_run = 0;
  logic [4:0]  log_addr [512];
  logic [31:0] log_data [512];
  logic        log_rwn  [512];
  int          log_idle [512];
  int          log_cyc  [512];
  logic        stalled_prev = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  // Responder controls, written only by the stimulus block
  logic [4:0]  stall_addr = '0;
  int          stall_n = 0, stall_base = 0;
  logic [31:0] st_mem [8];
  int          st_len = 0, st_base = 0, st_idx;
  logic [31:0] st_default = 32'h1;

  always_comb begin
    cfg_ready_i = !(cfg_valid_o && (cfg_addr_o == stall_addr) && ((stall_total - stall_base) < stall_n));
    st_idx      = rd_total - st_base;
    cfg_data_i  = st_default;
    if (st_idx >= 0 && st_idx < st_len && st_idx < 8) cfg_data_i = st_mem[st_idx];
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (cfg_valid_o && cfg_ready_i) begin
      log_addr[log_n] <= cfg_addr_o;
      log_data[log_n] <= cfg_data_o;
      log_rwn[log_n]  <= cfg_rwn_o;
      log_idle[log_n] <= idle_run;
      log_cyc[log_n]  <= cyc;
      log_n           <= (log_n + 1) % 512;
      if (cfg_rwn_o) rd_total <= rd_total + 1;
    end
    if (cfg_valid_o && !cfg_ready_i) stall_total <= stall_total + 1;
    if (stalled_prev && cfg_valid_o && (cfg_addr_o != prev_addr || cfg_data_o != prev_data))
      stable_err <= stable_err + 1;
    stalled_prev <= cfg_valid_o && !cfg_ready_i;
    prev_addr    <= cfg_addr_o;
    prev_data    <= cfg_data_o;
    idle_run     <= cfg_valid_o ? 0 : idle_run + 1;
  end

  task automatic send_req(input logic rx, input logic tx, input logic cont,
                          input logic [11:0] rxa, input logic [15:0] rxs,
                          input logic [11:0] txa, input logic [15:0] txs, output int acc);
    @(negedge clk_i);
    `CHK("req_ready_idle", req_ready_o, 1'b1)
    req_valid_i = 1'b1; req_rx_en_i = rx; req_tx_en_i = tx; req_continuous_i = cont;
    req_rx_saddr_i = rxa; req_rx_size_i = rxs; req_tx_saddr_i = txa; req_tx_size_i = txs;
    acc = cyc;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    `CHK("busy_after_accept", busy_o, 1'b1)
    `CHK("req_ready_after_accept", req_ready_o, 1'b0)
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_st, output int dcyc);
    int n = 0;
    while (done_o !== 1'b1 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    dcyc = cyc;
    `CHK({tag, "_done_seen"}, done_o, 1'b1)
    `CHK({tag, "_done_status"}, done_status_o, exp_st)
    `CHK({tag, "_ready_in_done"}, req_ready_o, 1'b0)
    `CHK({tag, "_busy_in_done"}, busy_o, 1'b1)
    @(negedge clk_i);
    `CHK({tag, "_done_one_cycle"}, done_o, 1'b0)
    `CHK({tag, "_ready_after_done"}, req_ready_o, 1'b1)
    `CHK({tag, "_busy_after_done"}, busy_o, 1'b0)
    `CHK({tag, "_status_held"}, done_status_o, exp_st)
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dcyc, base, sbase, ebase, n;
    logic [4:0]  ea [7];
    logic [31:0] ed [7];

    // Reset state
    repeat (3) @(negedge clk_i);
    `CHK("rst_req_ready", req_ready_o, 1'b1)
    `CHK("rst_busy", busy_o, 1'b0)
    `CHK("rst_done", done_o, 1'b0)
    `CHK("rst_status", done_status_o, 2'b00)
    `CHK("rst_cfg_valid", cfg_valid_o, 1'b0)
    rst_i = 1'b0;

    // 1: both channels, six back-to-back writes then a single read
    base = log_n; st_base = rd_total; st_mem[0] = 32'h0; st_len = 1;
    ea = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h06, 5'h08};
    ed = '{32'h100, 32'h8, 32'h10, 32'h200, 32'h4, 32'h10, 32'h0};
    send_req(1'b1, 1'b1, 1'b0, 12'h100, 16'd8, 12'h200, 16'd4, acc);
    `CHK("t1_first_valid", cfg_valid_o, 1'b1)
    wait_done("t1", 2'b00, dcyc);
    `CHK("t1_txn_count", log_n - base, 7)
    for (int k = 0; k < 6; k++) begin
      `CHK("t1_wr_addr", log_addr[base + k], ea[k])
      `CHK("t1_wr_data", log_data[base + k], ed[k])
      `CHK("t1_wr_rwn", log_rwn[base + k], 1'b0)
      `CHK("t1_wr_cycle", log_cyc[base + k], acc + 1 + k)
    end
    `CHK("t1_rd_addr", log_addr[base + 6], 5'h08)
    `CHK("t1_rd_rwn", log_rwn[base + 6], 1'b1)
    `CHK("t1_rd_gap", log_idle[base + 6], 16)
    `CHK("t1_rd_cycle", log_cyc[base + 6], acc + 23)
    `CHK("t1_done_cycle", dcyc, acc + 24)
    $display("[TB] t1 both-channel request: %0d bus transfers", log_n - base);

    // 2: TX only, continuous, TX_SIZE stalled three cycles
    base = log_n; st_base = rd_total; st_mem[0] = 32'h0; st_len = 1;
    stall_addr = 5'h05; stall_base = stall_total; stall_n = 3; sbase = stall_total; ebase = stable_err;
    send_req(1'b0, 1'b1, 1'b1, 12'h5A5, 16'h1234, 12'h3A0, 16'h20, acc);
    wait_done("t2", 2'b00, dcyc);
    stall_n = 0;
    `CHK("t2_txn_count", log_n - base, 4)
    `CHK("t2_addr0", log_addr[base], 5'h04)
    `CHK("t2_data0", log_data[base], 32'h3A0)
    `CHK("t2_addr1", log_addr[base + 1], 5'h05)
    `CHK("t2_data1", log_data[base + 1], 32'h20)
    `CHK("t2_cycle1", log_cyc[base + 1], acc + 5)
    `CHK("t2_addr2", log_addr[base + 2], 5'h06)
    `CHK("t2_data2", log_data[base + 2], 32'h11)
    `CHK("t2_stall_cycles", stall_total - sbase, 3)
    `CHK("t2_stable", stable_err - ebase, 0)
    $display("[TB] t2 tx-only stalled request: %0d bus transfers", log_n - base);

    // 3: poll-only, busy three times then idle
    base = log_n; st_base = rd_total;
    st_mem[0] = 32'h1; st_mem[1] = 32'h1; st_mem[2] = 32'h1; st_mem[3] = 32'h0; st_len = 4;
    send_req(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 12'h0, 16'h0, acc);
    wait_done("t3", 2'b00, dcyc);
    `CHK("t3_reads", log_n - base, 4)
    `CHK("t3_first_rd_cycle", log_cyc[base], acc + 17)
    for (int k = 1; k < 4; k++) begin
      `CHK("t3_rd_gap", log_idle[base + k], 16)
      `CHK("t3_rd_addr", log_addr[base + k], 5'h08)
    end
    $display("[TB] t3 poll-only request: %0d reads", log_n - base);

    // 4: RX only, arbitration lost reported together with busy
    base = log_n; st_base = rd_total; st_mem[0] = 32'h3; st_len = 1;
    send_req(1'b1, 1'b0, 1'b0, 12'h0FF, 16'hFFFF, 12'h111, 16'h1, acc);
    wait_done("t4", 2'b01, dcyc);
    `CHK("t4_txn_count", log_n - base, 4)
    `CHK("t4_data1", log_data[base + 1], 32'h0000FFFF)
    `CHK("t4_addr2", log_addr[base + 2], 5'h02)
    `CHK("t4_rd_addr", log_addr[base + 3], 5'h08)
    $display("[TB] t4 arbitration-lost request: %0d bus transfers", log_n - base);

    // 5: STATUS stuck busy -> timeout after MAX_POLLS reads
    base = log_n; st_base = rd_total; st_len = 0; st_default = 32'h1;
    send_req(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 12'h0, 16'h0, acc);
    wait_done("t5", 2'b10, dcyc);
    `CHK("t5_reads", rd_total - st_base, 4)
    $display("[TB] t5 timeout request: %0d reads", rd_total - st_base);

    // 6: reset while RX_CFG is stalled, then a clean request
    base = log_n; stall_addr = 5'h02; stall_base = stall_total; stall_n = 1000;
    send_req(1'b1, 1'b0, 1'b0, 12'h010, 16'h2, 12'h0, 16'h0, acc);
    n = 0;
    while (!(cfg_valid_o && cfg_addr_o == 5'h02) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    `CHK("t6_stalled_on_rx_cfg", cfg_addr_o, 5'h02)
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    stall_n = 0;
    `CHK("t6_valid_after_rst", cfg_valid_o, 1'b0)
    `CHK("t6_done_after_rst", done_o, 1'b0)
    `CHK("t6_ready_after_rst", req_ready_o, 1'b1)
    `CHK("t6_busy_after_rst", busy_o, 1'b0)
    `CHK("t6_status_after_rst", done_status_o, 2'b00)
    `CHK("t6_logged_before_rst", log_n - base, 2)
    base = log_n; st_base = rd_total; st_mem[0] = 32'h0; st_len = 1;
    send_req(1'b0, 1'b1, 1'b0, 12'h0, 16'h0, 12'h7FF, 16'h8, acc);
    wait_done("t6", 2'b00, dcyc);
    `CHK("t6_txn_count", log_n - base, 4)
    `CHK("t6_addr0", log_addr[base], 5'h04)
    `CHK("t6_data0", log_data[base], 32'h7FF)
    `CHK("t6_data2", log_data[base + 2], 32'h10)
    $display("[TB] t6 reset recovery request: %0d bus transfers", log_n - base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
